// File: rtl/sspim_arb.sv
// sspim_arb: shares one SPI master register port between two requesters, with lock and lock-timeout.
// Optional SSPIM_ARB_FIXED_PRI_EN: req0 always wins simultaneous requests (default is round-robin).
module sspim_arb #(
    parameter int unsigned      TMO_W    = 16,
    parameter logic [TMO_W-1:0] LOCK_TMO = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_cs,
    input  logic        req0_wr,
    input  logic [7:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_be,
    input  logic        req0_lock,
    output logic [31:0] req0_rdata,
    output logic        req0_ack,
    input  logic        req1_cs,
    input  logic        req1_wr,
    input  logic [7:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_be,
    input  logic        req1_lock,
    output logic [31:0] req1_rdata,
    output logic        req1_ack,
    output logic        m_reg_cs,
    output logic        m_reg_wr,
    output logic [7:0]  m_reg_addr,
    output logic [31:0] m_reg_wdata,
    output logic [3:0]  m_reg_be,
    input  logic [31:0] m_reg_rdata,
    input  logic        m_reg_ack,
    output logic [1:0]  grant,
    output logic        tmo_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = LOCK_TMO - {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [1:0]       grant_nxt;
    logic [TMO_W-1:0] cnt, cnt_nxt;
    logic             tmo_nxt;
    logic             issue, issue_sel, cs_clr;
    logic             own, owner_cs, owner_lock;
    logic             arb_sel;
    logic             ack_ok;

    assign own        = grant[1];
    assign owner_cs   = own ? req1_cs   : req0_cs;
    assign owner_lock = own ? req1_lock : req0_lock;

`ifdef SSPIM_ARB_FIXED_PRI_EN
    assign arb_sel = ~req0_cs;
`else
    logic ptr;

    // Any return to IDLE from a granted state hands priority to the other requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= 1'b0;
        else if (state != IDLE && state_nxt == IDLE)
            ptr <= ~own;
    end

    assign arb_sel = (req0_cs & req1_cs) ? ptr : req1_cs;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        issue     = 1'b0;
        issue_sel = own;
        cs_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_cs | req1_cs) begin
                    issue     = 1'b1;
                    issue_sel = arb_sel;
                    grant_nxt = arb_sel ? 2'b10 : 2'b01;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (m_reg_ack) begin
                    cs_clr = 1'b1;
                    if (owner_lock) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 2'b00;
                    end
                end
            end
            LOCKED: begin
                if (owner_cs) begin
                    issue     = 1'b1;
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end else if (!owner_lock) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                    tmo_nxt   = 1'b1;
                end else if (cnt != {TMO_W{1'b1}}) begin
                    cnt_nxt = cnt + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= 2'b00;
            cnt     <= '0;
            tmo_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            tmo_err <= tmo_nxt;
        end
    end

    // Master-side request is registered at the grant edge and held until the ack edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg_cs    <= 1'b0;
            m_reg_wr    <= 1'b0;
            m_reg_addr  <= '0;
            m_reg_wdata <= '0;
            m_reg_be    <= '0;
        end else if (issue) begin
            m_reg_cs    <= 1'b1;
            m_reg_wr    <= issue_sel ? req1_wr    : req0_wr;
            m_reg_addr  <= issue_sel ? req1_addr  : req0_addr;
            m_reg_wdata <= issue_sel ? req1_wdata : req0_wdata;
            m_reg_be    <= issue_sel ? req1_be    : req0_be;
        end else if (cs_clr) begin
            m_reg_cs    <= 1'b0;
        end
    end

    // An owner that dropped cs before the ack does not see the ack.
    assign ack_ok     = (state == ACCESS) & m_reg_ack;
    assign req0_ack   = ack_ok & grant[0] & req0_cs;
    assign req1_ack   = ack_ok & grant[1] & req1_cs;
    assign req0_rdata = req0_ack ? m_reg_rdata : 32'h0;
    assign req1_rdata = req1_ack ? m_reg_rdata : 32'h0;

endmodule

// File: tb/tb_sspim_arb.sv
// Directed table-driven bench for sspim_arb (LOCK_TMO=8) plus an async-reset-mid-access sequence.
module tb_sspim_arb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_cs = 1'b0, req0_lock = 1'b0, req0_ack;
    logic        req1_cs = 1'b0, req1_lock = 1'b0, req1_ack;
    logic [31:0] req0_rdata, req1_rdata;
    logic        m_reg_cs, m_reg_wr, m_reg_ack = 1'b0, tmo_err;
    logic [7:0]  m_reg_addr;
    logic [31:0] m_reg_wdata;
    logic [3:0]  m_reg_be;
    logic [1:0]  grant;

    localparam logic        R0_WR = 1'b1;
    localparam logic [7:0]  R0_AD = 8'h04;
    localparam logic [31:0] R0_WD = 32'hA5A5_0001;
    localparam logic [3:0]  R0_BE = 4'hF;
    localparam logic        R1_WR = 1'b0;
    localparam logic [7:0]  R1_AD = 8'h08;
    localparam logic [31:0] R1_WD = 32'h0000_1111;
    localparam logic [3:0]  R1_BE = 4'h3;
    localparam logic [31:0] RDAT  = 32'hDEAD_BEEF;

`ifdef SSPIM_ARB_FIXED_PRI_EN
    localparam logic [1:0] G2 = 2'b01;
`else
    localparam logic [1:0] G2 = 2'b10;
`endif

    sspim_arb #(.TMO_W(16), .LOCK_TMO(16'd8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_cs(req0_cs), .req0_wr(R0_WR), .req0_addr(R0_AD), .req0_wdata(R0_WD),
        .req0_be(R0_BE), .req0_lock(req0_lock), .req0_rdata(req0_rdata), .req0_ack(req0_ack),
        .req1_cs(req1_cs), .req1_wr(R1_WR), .req1_addr(R1_AD), .req1_wdata(R1_WD),
        .req1_be(R1_BE), .req1_lock(req1_lock), .req1_rdata(req1_rdata), .req1_ack(req1_ack),
        .m_reg_cs(m_reg_cs), .m_reg_wr(m_reg_wr), .m_reg_addr(m_reg_addr),
        .m_reg_wdata(m_reg_wdata), .m_reg_be(m_reg_be), .m_reg_rdata(RDAT),
        .m_reg_ack(m_reg_ack), .grant(grant), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       cs0, cs1, lk0, lk1, mack;
        bit       mcs;
        bit [1:0] g;
        bit       a0, a1, tmo;
    } vec_t;

    vec_t vec[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(bit rst, bit cs0, bit cs1, bit lk0, bit lk1, bit mack,
                               bit mcs, bit [1:0] g, bit a0, bit a1, bit tmo);
        vec_t r;
        r.rst = rst; r.cs0 = cs0; r.cs1 = cs1; r.lk0 = lk0; r.lk1 = lk1; r.mack = mack;
        r.mcs = mcs; r.g = g; r.a0 = a0; r.a1 = a1; r.tmo = tmo;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req0_cs = 0; req1_cs = 0; req0_lock = 0; req1_lock = 0; m_reg_ack = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // single req0 write, slave acks in the third access cycle
        vec.push_back(v(1, 0,0,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,0,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,0,0,0,0, 1,2'b01,0,0,0));
        vec.push_back(v(0, 1,0,0,0,0, 1,2'b01,0,0,0));
        vec.push_back(v(0, 1,0,0,0,1, 1,2'b01,1,0,0));
        vec.push_back(v(0, 0,0,0,0,0, 0,2'b00,0,0,0));
        // simultaneous requests: req0 first, then alternation (or req0 again with fixed priority)
        vec.push_back(v(1, 1,1,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,1,0,0,1, 1,2'b01,1,0,0));
        vec.push_back(v(0, 1,1,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,1,0,0,1, 1,G2,G2[0],G2[1],0));
        vec.push_back(v(0, 0,0,0,0,0, 0,2'b00,0,0,0));
        // req0 locked over three accesses while req1 waits
        vec.push_back(v(1, 1,1,1,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,1,1,0,1, 1,2'b01,1,0,0));
        vec.push_back(v(0, 1,1,1,0,0, 0,2'b01,0,0,0));
        vec.push_back(v(0, 1,1,1,0,1, 1,2'b01,1,0,0));
        vec.push_back(v(0, 1,1,1,0,0, 0,2'b01,0,0,0));
        vec.push_back(v(0, 1,1,0,0,1, 1,2'b01,1,0,0));
        vec.push_back(v(0, 0,1,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 0,1,0,0,1, 1,2'b10,0,1,0));
        vec.push_back(v(0, 0,0,0,0,0, 0,2'b00,0,0,0));
        // lock timeout: 8 idle LOCKED cycles, then tmo_err and hand-off to req1
        vec.push_back(v(1, 1,0,1,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 1,1,1,0,1, 1,2'b01,1,0,0));
        for (int i = 0; i < 8; i++)
            vec.push_back(v(0, 0,1,1,0,0, 0,2'b01,0,0,0));
        vec.push_back(v(0, 0,1,1,0,0, 0,2'b00,0,0,1));
        vec.push_back(v(0, 0,1,0,0,1, 1,2'b10,0,1,0));
        vec.push_back(v(0, 0,0,0,0,0, 0,2'b00,0,0,0));
        // owner drops cs before ack; lock alone never acquires a grant
        vec.push_back(v(0, 1,0,0,0,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 0,0,0,0,1, 1,2'b01,0,0,0));
        vec.push_back(v(0, 0,0,0,1,0, 0,2'b00,0,0,0));
        vec.push_back(v(0, 0,0,0,1,0, 0,2'b00,0,0,0));

        for (int i = 0; i < vec.size(); i++) begin
            if (vec[i].rst) do_reset();
            @(negedge clk);
            req0_cs = vec[i].cs0; req1_cs = vec[i].cs1;
            req0_lock = vec[i].lk0; req1_lock = vec[i].lk1;
            m_reg_ack = vec[i].mack;
            #1;
            chk($sformatf("v%0d m_reg_cs", i), {31'b0, m_reg_cs}, {31'b0, vec[i].mcs});
            chk($sformatf("v%0d grant", i), {30'b0, grant}, {30'b0, vec[i].g});
            chk($sformatf("v%0d req0_ack", i), {31'b0, req0_ack}, {31'b0, vec[i].a0});
            chk($sformatf("v%0d req1_ack", i), {31'b0, req1_ack}, {31'b0, vec[i].a1});
            chk($sformatf("v%0d tmo_err", i), {31'b0, tmo_err}, {31'b0, vec[i].tmo});
            chk($sformatf("v%0d req0_rdata", i), req0_rdata, vec[i].a0 ? RDAT : 32'h0);
            chk($sformatf("v%0d req1_rdata", i), req1_rdata, vec[i].a1 ? RDAT : 32'h0);
            if (vec[i].g == 2'b01) begin
                chk($sformatf("v%0d addr0", i), {24'b0, m_reg_addr}, {24'b0, R0_AD});
                chk($sformatf("v%0d be0", i), {28'b0, m_reg_be}, {28'b0, R0_BE});
            end else if (vec[i].g == 2'b10) begin
                chk($sformatf("v%0d addr1", i), {24'b0, m_reg_addr}, {24'b0, R1_AD});
                chk($sformatf("v%0d be1", i), {28'b0, m_reg_be}, {28'b0, R1_BE});
            end
        end

        // async reset while the master access is in flight
        do_reset();
        @(negedge clk);
        req0_cs = 1'b1; req1_cs = 1'b1;
        @(negedge clk);
        #1;
        chk("mid m_reg_cs", {31'b0, m_reg_cs}, 32'd1);
        chk("mid m_reg_wr", {31'b0, m_reg_wr}, {31'b0, R0_WR});
        chk("mid m_reg_wdata", m_reg_wdata, R0_WD);
        #2;
        reset_n = 1'b0;
        m_reg_ack = 1'b1;
        #1;
        chk("rst m_reg_cs", {31'b0, m_reg_cs}, 32'd0);
        chk("rst grant", {30'b0, grant}, 32'd0);
        chk("rst m_reg_addr", {24'b0, m_reg_addr}, 32'd0);
        chk("rst m_reg_wdata", m_reg_wdata, 32'd0);
        chk("rst m_reg_be", {28'b0, m_reg_be}, 32'd0);
        chk("rst m_reg_wr", {31'b0, m_reg_wr}, 32'd0);
        chk("rst req0_ack", {31'b0, req0_ack}, 32'd0);
        chk("rst req1_ack", {31'b0, req1_ack}, 32'd0);
        chk("rst req0_rdata", req0_rdata, 32'd0);
        chk("rst tmo_err", {31'b0, tmo_err}, 32'd0);
        @(negedge clk);
        m_reg_ack = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-rst grant", {30'b0, grant}, 32'd1);
        chk("post-rst m_reg_addr", {24'b0, m_reg_addr}, {24'b0, R0_AD});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
